// File: rtl/hazard_if.sv
// Pipeline-control bundle between the RV32I datapath and the hazard scheduler.
// master = pipeline/datapath side, slave = scheduler.
interface hazard_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
    logic [4:0]       RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MemAccessM;
    logic             dmem_ready;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             dmem_req;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MemAccessM, dmem_ready,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, dmem_req, mem_timeout, stall_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MemAccessM, dmem_ready,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, dmem_req, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard/stall scheduler for the 5-stage RV32I pipeline: forwarding, load-use stall,
// branch flush and multi-cycle data-memory hold with watchdog and stall counter.
module hazard_scheduler #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave bus
);
    localparam int unsigned WcntW = $clog2(MAX_WAIT) + 1;

    typedef enum logic {StIdle, StWait} state_e;

    state_e           state_q, state_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lw_stall, mem_stall, timeout_evt, req, stall_f;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == rs) return 2'b10;
        if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Memory wait FSM and watchdog.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        mem_timeout_d = mem_timeout_q;
        timeout_evt   = 1'b0;
        req           = 1'b0;
        unique case (state_q)
            StIdle: begin
                req = bus.MemAccessM;
                if (bus.MemAccessM && !bus.dmem_ready) begin
                    state_d = StWait;
                    wcnt_d  = WcntW'(1);
                end
            end
            StWait: begin
                req = 1'b1;
                if (bus.dmem_ready) begin
                    state_d = StIdle;
                    wcnt_d  = '0;
                end else if (wcnt_q == WcntW'(MAX_WAIT - 1)) begin
                    timeout_evt   = 1'b1;
                    mem_timeout_d = 1'b1;
                    state_d       = StIdle;
                    wcnt_d        = '0;
                end else begin
                    wcnt_d = wcnt_q + WcntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Abandoning a timed-out access releases M instead of holding it.
    assign mem_stall = bus.MemAccessM && !bus.dmem_ready && !timeout_evt;
    assign lw_stall  = (bus.ResultSrcE == 2'b01) && (bus.RdE != 5'd0) &&
                       ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D)) && !bus.PCSrcE;
    assign stall_f   = mem_stall || lw_stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.ForwardAE = 2'b00;
        bus.ForwardBE = 2'b00;
        bus.StallF    = 1'b0;
        bus.StallD    = 1'b0;
        bus.StallE    = 1'b0;
        bus.StallM    = 1'b0;
        bus.FlushD    = 1'b1;
        bus.FlushE    = 1'b1;
        bus.FlushW    = 1'b1;
        bus.dmem_req  = 1'b0;
        if (!rst) begin
            bus.ForwardAE = fwd_sel(bus.Rs1E);
            bus.ForwardBE = fwd_sel(bus.Rs2E);
            bus.StallF    = stall_f;
            bus.StallD    = stall_f;
            bus.StallE    = mem_stall;
            bus.StallM    = mem_stall;
            bus.FlushD    = bus.PCSrcE && !mem_stall;
            bus.FlushE    = (bus.PCSrcE || lw_stall) && !mem_stall;
            bus.FlushW    = mem_stall || timeout_evt;
            bus.dmem_req  = req;
        end
    end

    assign bus.mem_timeout = mem_timeout_q;
    assign bus.stall_cnt   = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wcnt_q        <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with MAX_WAIT = 4 and CNT_W = 4.
module tb_hazard_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    hazard_if #(.CNT_W(4)) bus ();

    hazard_scheduler #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
        bus.RdE = 0; bus.RdM = 0; bus.RdW = 0;
        bus.RegWriteM = 0; bus.RegWriteW = 0; bus.ResultSrcE = 0;
        bus.PCSrcE = 0; bus.MemAccessM = 0; bus.dmem_ready = 0;
    endtask

    initial begin
        clear();
        rst = 1'b1;
        bus.RegWriteM = 1; bus.RdM = 5; bus.Rs1E = 5; bus.MemAccessM = 1;
        tick();
        chk("rst_stallF", 32'(bus.StallF), 0);
        chk("rst_flushD", 32'(bus.FlushD), 1);
        chk("rst_flushE", 32'(bus.FlushE), 1);
        chk("rst_flushW", 32'(bus.FlushW), 1);
        chk("rst_req", 32'(bus.dmem_req), 0);
        chk("rst_fwdA", 32'(bus.ForwardAE), 0);
        chk("rst_cnt", 32'(bus.stall_cnt), 0);
        chk("rst_tmo", 32'(bus.mem_timeout), 0);
        rst = 1'b0;
        clear();

        // Forwarding priority.
        bus.RdM = 5; bus.RegWriteM = 1; bus.Rs1E = 5; bus.RdW = 5; bus.RegWriteW = 1;
        #1 chk("fwdA_M", 32'(bus.ForwardAE), 2);
        bus.RdM = 0;
        #1 chk("fwdA_W", 32'(bus.ForwardAE), 1);
        bus.RdM = 5; bus.RegWriteM = 0;
        #1 chk("fwdA_noweM", 32'(bus.ForwardAE), 1);
        bus.Rs2E = 5;
        #1 chk("fwdB_W", 32'(bus.ForwardBE), 1);
        bus.Rs2E = 0; bus.RdW = 0;
        #1 chk("fwdB_x0", 32'(bus.ForwardBE), 0);
        chk("fwdA_none", 32'(bus.ForwardAE), 0);
        clear();

        // Load-use stall, then masked by a taken branch.
        bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7;
        #1 chk("lw_stallF", 32'(bus.StallF), 1);
        chk("lw_stallD", 32'(bus.StallD), 1);
        chk("lw_flushE", 32'(bus.FlushE), 1);
        chk("lw_stallE", 32'(bus.StallE), 0);
        chk("lw_flushD", 32'(bus.FlushD), 0);
        tick();
        chk("lw_cnt", 32'(bus.stall_cnt), 1);
        bus.PCSrcE = 1;
        #1 chk("lwbr_stallF", 32'(bus.StallF), 0);
        chk("lwbr_flushD", 32'(bus.FlushD), 1);
        chk("lwbr_flushE", 32'(bus.FlushE), 1);
        tick();
        chk("lwbr_cnt", 32'(bus.stall_cnt), 1);
        clear();

        // Three-cycle memory wait then completion.
        bus.MemAccessM = 1;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("mw%0d_req", i), 32'(bus.dmem_req), 1);
            chk($sformatf("mw%0d_stall", i),
                32'({bus.StallF, bus.StallD, bus.StallE, bus.StallM}), 4'hf);
            chk($sformatf("mw%0d_flushW", i), 32'(bus.FlushW), 1);
            tick();
        end
        bus.dmem_ready = 1;
        #1 chk("mw4_req", 32'(bus.dmem_req), 1);
        chk("mw4_stallF", 32'(bus.StallF), 0);
        chk("mw4_flushW", 32'(bus.FlushW), 0);
        tick();
        clear();
        #1 chk("mw_idle_req", 32'(bus.dmem_req), 0);
        chk("mw_cnt", 32'(bus.stall_cnt), 4);
        chk("mw_tmo", 32'(bus.mem_timeout), 0);

        // Watchdog timeout on the fourth waiting cycle.
        bus.MemAccessM = 1;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("to%0d_stallF", i), 32'(bus.StallF), 1);
            tick();
        end
        #1 chk("to4_stall", 32'({bus.StallF, bus.StallD, bus.StallE, bus.StallM}), 0);
        chk("to4_flushW", 32'(bus.FlushW), 1);
        chk("to4_tmo_pre", 32'(bus.mem_timeout), 0);
        tick();
        clear();
        #1 chk("to_tmo_set", 32'(bus.mem_timeout), 1);
        chk("to_cnt", 32'(bus.stall_cnt), 7);
        tick(); tick();
        chk("to_tmo_sticky", 32'(bus.mem_timeout), 1);

        // Redirect pending during a two-cycle memory wait.
        bus.MemAccessM = 1; bus.PCSrcE = 1;
        for (int i = 1; i <= 2; i++) begin
            #1 chk($sformatf("rd%0d_flushD", i), 32'(bus.FlushD), 0);
            chk($sformatf("rd%0d_flushE", i), 32'(bus.FlushE), 0);
            chk($sformatf("rd%0d_stallF", i), 32'(bus.StallF), 1);
            tick();
        end
        bus.dmem_ready = 1;
        #1 chk("rd_rel_flushD", 32'(bus.FlushD), 1);
        chk("rd_rel_flushE", 32'(bus.FlushE), 1);
        chk("rd_rel_stallF", 32'(bus.StallF), 0);
        tick();
        clear();
        chk("rd_cnt", 32'(bus.stall_cnt), 9);

        // Reset in the middle of a wait.
        bus.MemAccessM = 1;
        tick(); tick();
        rst = 1'b1;
        #1 chk("rw_req", 32'(bus.dmem_req), 0);
        chk("rw_flush", 32'({bus.FlushD, bus.FlushE, bus.FlushW}), 3'b111);
        chk("rw_stallF", 32'(bus.StallF), 0);
        tick();
        chk("rw_cnt", 32'(bus.stall_cnt), 0);
        chk("rw_tmo", 32'(bus.mem_timeout), 0);
        rst = 1'b0;
        bus.MemAccessM = 0;
        #1 chk("rw_idle_req", 32'(bus.dmem_req), 0);
        // A fresh wait must run the full count again before timing out.
        bus.MemAccessM = 1;
        tick(); tick(); tick();
        #1 chk("rw_wait3_stallF", 32'(bus.StallF), 0);
        chk("rw_wait3_flushW", 32'(bus.FlushW), 1);
        tick();
        clear();
        tick();

        // Counter saturation with CNT_W = 4.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ResultSrcE = 2'b01; bus.RdE = 3; bus.Rs1D = 3;
        for (int i = 0; i < 15; i++) tick();
        chk("sat_15", 32'(bus.stall_cnt), 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", 32'(bus.stall_cnt), 15);
        clear();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
